// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response handshake of the load/store unit.
// The pipeline drives requests through the master modport, and the unit answers through the slave modport.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for the word-addressed dataMemory.
// Sub-word stores use read-modify-write, and sub-word loads are sign- or zero-extended.
module load_store_unit #(
    parameter int unsigned DEPTH = 4096
) (
    input  logic              CLK,
    input  logic              RST_N,
    load_store_unit_if.slave  bus,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign bus.req_ready = (state == IDLE);

    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = |bus.req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= DEPTH)
            req_err = 1'b1;
    end

    // Lane extraction and merge both work on the memory word that was just read.
    always_comb begin
        rd_byte  = mem_dout[{addr_q[1:0], 3'b000} +: 8];
        rd_half  = mem_dout[{addr_q[1], 4'b0000} +: 16];
        load_val = mem_dout;
        merged   = mem_dout;
        case (size_q)
            2'b00: begin
                load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = {{16{signed_q & rd_half[15]}}, rd_half};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // The strobes are gated by RST_N so that a reset edge can never commit a write.
    always_comb begin
        mem_rd   = RST_N && (state == RD);
        mem_wr   = RST_N && ((state == WR) || (state == DATA && we_q));
        mem_addr = '0;
        mem_din  = '0;
        if (state == RD || state == DATA || state == WR)
            mem_addr = {2'b00, addr_q[31:2]};
        if (state == WR)
            mem_din = wdata_q;
        else if (state == DATA && we_q)
            mem_din = merged;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        if (req_err) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= '0;
                            bus.resp_err   <= 1'b1;
                            state          <= RESP;
                        end else if (bus.req_we && bus.req_size == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= DATA;
                DATA: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= we_q ? '0 : load_val;
                    bus.resp_err   <= 1'b0;
                    state          <= RESP;
                end
                WR: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-output word memory model.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout;
    logic [31:0] mem [0:4095];
    logic        preloaded = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;

    load_store_unit_if bus();

    load_store_unit #(.DEPTH(4096)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .bus      (bus),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!preloaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[0]    <= 32'd12;
            mem[1]    <= 32'h80FF7F01;
            mem[2]    <= 32'h11223344;
            mem[4095] <= 32'hCAFEF00D;
            preloaded <= 1'b1;
        end else begin
            if (mem_wr) mem[mem_addr[11:0]] <= mem_din;
            if (mem_rd) mem_dout <= mem[mem_addr[11:0]];
        end
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_rd, input int exp_wr, input int hold);
        int rd0, wr0, lat;
        logic [31:0] rdata;
        @(negedge CLK);
        check({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        rdata = bus.resp_rdata;
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            check({tag, "_hold_valid"}, {31'd0, bus.resp_valid}, 32'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, rdata);
            check({tag, "_hold_rdy"}, {31'd0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge CLK); #1;
        bus.resp_ready = 1'b0;
        check({tag, "_done_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "_done_rdy"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        int wr0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rst_rdy", {31'd0, bus.req_ready}, 32'd1);
        check("idle_addr", mem_addr, 32'd0);

        // tag, we, size, signed, addr, wdata, rdata, err, lat, nrd, nwr, hold
        do_req("ld_w0",   1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'd12,        1'b0, 3, 1, 0, 0);
        do_req("ldb4s",   1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'h00000001,  1'b0, 3, 1, 0, 0);
        do_req("ldb5s",   1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'h0000007F,  1'b0, 3, 1, 0, 0);
        do_req("ldb6s",   1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 32'hFFFFFFFF,  1'b0, 3, 1, 0, 0);
        do_req("ldb7s",   1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'hFFFFFF80,  1'b0, 3, 1, 0, 0);
        do_req("ldb7u",   1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h00000080,  1'b0, 3, 1, 0, 0);
        do_req("ldh6s",   1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFF80FF,  1'b0, 3, 1, 0, 0);
        do_req("ldh6u",   1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h000080FF,  1'b0, 3, 1, 0, 0);
        do_req("ldh4s",   1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h00007F01,  1'b0, 3, 1, 0, 0);
        do_req("ld_top",  1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0, 0);

        do_req("stb_a",   1'b1, 2'b00, 1'b0, 32'hA, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1, 1, 0);
        check("mem2_b", mem[2], 32'h11AA3344);
        do_req("sth_8",   1'b1, 2'b01, 1'b0, 32'h8, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1, 0);
        check("mem2_h", mem[2], 32'h11AABEEF);
        do_req("stw_c",   1'b1, 2'b10, 1'b0, 32'hC, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 0);
        check("mem3_w", mem[3], 32'hDEADBEEF);
        do_req("ldw_c",   1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hDEADBEEF,  1'b0, 3, 1, 0, 0);

        do_req("err_h3",  1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_w2",  1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_sz",  1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_oob", 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_stw", 1'b1, 2'b10, 1'b0, 32'h4000, 32'h55555555, 32'h0, 1'b1, 1, 0, 0, 0);
        do_req("err_sth", 1'b1, 2'b01, 1'b0, 32'h9, 32'h5555, 32'h0, 1'b1, 1, 0, 0, 0);
        check("mem0_kept", mem[0], 32'd12);
        check("mem2_kept", mem[2], 32'h11AABEEF);

        do_req("stall",   1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h00000080, 1'b0, 3, 1, 0, 5);

        // Reset lands while the sub-word store sits in DATA with its write strobe up.
        @(negedge CLK);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h9;
        bus.req_wdata  = 32'h00000055;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        wr0 = wr_cnt;
        @(posedge CLK);
        @(negedge CLK);
        check("data_wr", {31'd0, mem_wr}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("rst_gate_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_mid_rdy", {31'd0, bus.req_ready}, 32'd1);
        check("rst_mid_nwr", 32'(wr_cnt - wr0), 32'd0);
        check("rst_mid_mem2", mem[2], 32'h11AABEEF);
        do_req("ld_after", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h11AABEEF, 1'b0, 3, 1, 0, 0);

        check("rd_wr_overlap", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side front end for the word-addressed data memory (`dataMemory`). It accepts byte, halfword and word load/store requests on a valid/ready handshake and converts byte addresses to word addresses. It drives the memory's `rd`/`wr`/`add_lines`/`d_in` and captures its registered `d_out`, performing read-modify-write for sub-word stores and sign/zero extension for sub-word loads. Exactly one request is in flight at a time.

## Interface
- `DEPTH`, 4096: memory depth in 32-bit words; word addresses ≥ DEPTH are errors.
- `CLK`  in  1  clock; all state changes on posedge.
- `RST_N`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high exactly in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend sub-word loads; ignored for stores.
- `req_addr`  in  32  byte address, little-endian lanes.
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  request rejected, no memory access made.
- `mem_rd`  out  1  to memory `rd`.
- `mem_wr`  out  1  to memory `wr`.
- `mem_addr`  out  32  to memory `add_lines`; = {2'b00, addr[31:2]}.
- `mem_din`  out  32  to memory `d_in`.
- `mem_dout`  in  32  from memory `d_out`; valid the cycle after the edge that sampled `mem_rd`.

## Operation
- States: IDLE, RD, DATA, WR, RESP. Request fields latched on acceptance (`req_valid && req_ready` at an edge).
- Error check at acceptance: size 11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ DEPTH. Error → RESP with `resp_err`=1, `resp_rdata`=0, no memory strobe.
- Load: IDLE → RD (`mem_rd`=1) → DATA (`mem_dout` valid; lane select by addr[1:0]: byte lane addr[1:0], half lane addr[1]; extend per `req_signed`; register into `resp_rdata`) → RESP.
- Word store: IDLE → WR (`mem_wr`=1, `mem_din`=wdata) → RESP.
- Sub-word store: IDLE → RD (`mem_rd`=1) → DATA (`mem_wr`=1, `mem_din` = `mem_dout` with target lane(s) replaced by wdata[7:0]/[15:0], combinational from `mem_dout`) → RESP. Untouched lanes preserved bit-exact.
- RESP: `resp_valid`=1, `resp_rdata`/`resp_err` stable until `resp_ready` sampled high → IDLE. `req_ready`=0 in RESP; no new request accepted in the same cycle as the response handshake.
- `mem_rd` and `mem_wr` never high together; both gated by `RST_N` combinationally, so no memory write occurs at a reset edge.
- `mem_addr`/`mem_din` held at latched values in RD/DATA/WR; don't-care otherwise (drive 0 in IDLE).

## Timing
- Reset (`RST_N`=0 at an edge): state IDLE; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, latched request cleared; `mem_rd`=`mem_wr`=0 whenever `RST_N`=0. `req_ready`=1 from the first cycle after reset release.
- Reset mid-operation: transaction abandoned, no response; a sub-word store reset in DATA performs no write.
- Latency, acceptance edge to `resp_valid` high: load 3 cycles, sub-word store 3, word store 2, error 1.
- Back-to-back: next request accepted earliest one cycle after response handshake; throughput 1 op per 3 (word store) or 4 (other) cycles with `resp_ready` tied high.
- `resp_ready` low: unit stalls in RESP indefinitely; outputs unchanged.

## Test plan
- Memory word 0 = 12; load word addr 0x0 → `resp_rdata`=12, `resp_err`=0, `resp_valid` 3 cycles after acceptance.
- Word 1 = 0x80FF7F01; byte loads addr 0x4..0x7 signed → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned byte at 0x7 → 0x00000080; signed half at 0x6 → 0xFFFF80FF.
- Word 2 = 0x11223344; store byte 0xAA at addr 0xA → word 2 = 0x11AA3344; store half 0xBEEF at 0x8 → 0x11AABEEF; exactly one `mem_wr` pulse each.
- Misaligned half at 0x3, word at 0x2, size 11, addr 0x4000 (word 4096) → `resp_err`=1 one cycle after acceptance, no `mem_rd`/`mem_wr` pulses, memory unchanged.
- Hold `resp_ready`=0 for 5 cycles after a load → `resp_valid`/`resp_rdata` stable, `req_ready`=0; release → IDLE next cycle.
- Assert `RST_N`=0 during DATA of sub-word store to word 2 → no write, word 2 unchanged, `resp_valid`=0, `req_ready`=1 after release.
